sd_spi_responder: RTL



---
 rtl/sd_spi_responder.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SPI-mode SD card emulator serving R1/R3/R7 and single-block reads/writes
module sd_spi_responder #(
  parameter int ADDR_W     = 16,
  parameter int NAC_BYTES  = 2,
  parameter int BUSY_BYTES = 4
) (
  input  logic              sys_clk_pad_i,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              card_ready
);
  localparam int ARG_W = (ADDR_W - 9 > 8) ? ADDR_W - 9 : 8;
  localparam logic [9:0] NAC_LAST = 10'(NAC_BYTES - 1);
  localparam logic [9:0] BUSY_CNT = 10'(BUSY_BYTES);

  typedef enum logic [3:0] {
    WAIT_CMD, CMD_RX, NCR, RESP, RD_NAC, RD_DATA, WR_TOKEN, WR_DATA, WR_RESP
  } state_t;

  state_t state, state_nxt;

  logic [1:0] cs_sync, sclk_sync, mosi_sync;
  logic       sclk_d;
  logic       cs_s, sclk_s, mosi_s, sclk_rise, sclk_fall;

  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr, tx_byte, rx_byte;
  logic       byte_done;

  logic [9:0]       cnt, trail_len;
  logic [5:0]       cmd_idx;
  logic [ARG_W-1:0] arg;
  logic             illegal_q, app_cmd, idle_bit, cmd_legal, rd_ok, wr_ok;
  logic [7:0]       trailer, pf_data;
  logic             rd_pend, re_go, we_go;
  logic [8:0]       re_idx;

  always_ff @(posedge sys_clk_pad_i) begin
    if (rst) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b11;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
    end
  end

  assign cs_s      = cs_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr, mosi_s};

  // The next TX byte is loaded on the 8th rising edge; its MSB leaves on the following falling edge.
  always_ff @(posedge sys_clk_pad_i) begin
    if (rst || cs_s) begin
      bit_cnt <= 3'd0;
      rx_sr   <= 7'd0;
      tx_sr   <= 8'hFF;
      miso    <= 1'b1;
    end else begin
      if (sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sr   <= {rx_sr[5:0], mosi_s};
      end
      if (byte_done) begin
        tx_sr <= tx_byte;
      end else if (sclk_fall) begin
        tx_sr <= {tx_sr[6:0], 1'b1};
      end
      if (sclk_fall) miso <= tx_sr[7];
    end
  end

  always_comb begin
    cmd_legal = 1'b0;
    case (cmd_idx)
      6'd0, 6'd8, 6'd16, 6'd55, 6'd58: cmd_legal = 1'b1;
      6'd41:                           cmd_legal = app_cmd;
      6'd17, 6'd24:                    cmd_legal = ~idle_bit;
      default:                         cmd_legal = 1'b0;
    endcase
  end

  assign rd_ok     = (cmd_idx == 6'd17) && !illegal_q;
  assign wr_ok     = (cmd_idx == 6'd24) && !illegal_q;
  assign trail_len = ((cmd_idx == 6'd8) || (cmd_idx == 6'd58)) ? 10'd4 : 10'd0;

  always_comb begin
    trailer = 8'h00;
    if (cmd_idx == 6'd8) begin
      case (cnt[1:0])
        2'd2:    trailer = 8'h01;
        2'd3:    trailer = arg[7:0];
        default: trailer = 8'h00;
      endcase
    end else begin
      case (cnt[1:0])
        2'd0:    trailer = card_ready ? 8'hC0 : 8'h00;
        2'd1:    trailer = 8'hFF;
        2'd2:    trailer = 8'h80;
        default: trailer = 8'h00;
      endcase
    end
  end

  always_ff @(posedge sys_clk_pad_i) begin
    if (rst) state <= WAIT_CMD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_s) begin
      state_nxt = WAIT_CMD;
    end else if (byte_done) begin
      case (state)
        WAIT_CMD: if (rx_byte[7:6] == 2'b01) state_nxt = CMD_RX;
        CMD_RX:   if (cnt == 10'd4) state_nxt = NCR;
        NCR:      state_nxt = RESP;
        RESP: if (cnt >= trail_len) begin
          if (rd_ok)      state_nxt = (NAC_BYTES == 0) ? RD_DATA : RD_NAC;
          else if (wr_ok) state_nxt = WR_TOKEN;
          else            state_nxt = WAIT_CMD;
        end
        RD_NAC:   if (cnt == NAC_LAST) state_nxt = RD_DATA;
        RD_DATA:  if (cnt == 10'd513) state_nxt = WAIT_CMD;
        WR_TOKEN: if (rx_byte == 8'hFE) state_nxt = WR_DATA;
        WR_DATA:  if (cnt == 10'd513) state_nxt = WR_RESP;
        WR_RESP:  if (cnt == BUSY_CNT) state_nxt = WAIT_CMD;
        default:  state_nxt = WAIT_CMD;
      endcase
    end
  end

  // Reads prefetch one byte ahead so the memory data sits in pf_data before it is loaded.
  always_comb begin
    tx_byte = 8'hFF;
    re_go   = 1'b0;
    we_go   = 1'b0;
    re_idx  = 9'd0;
    case (state)
      NCR: tx_byte = {5'b0, ~cmd_legal, 1'b0, (cmd_idx == 6'd0) | idle_bit};
      RESP: begin
        if (cnt < trail_len) begin
          tx_byte = trailer;
        end else if (rd_ok && (NAC_BYTES == 0)) begin
          tx_byte = 8'hFE;
          re_go   = byte_done;
        end
      end
      RD_NAC: if (cnt == NAC_LAST) begin
        tx_byte = 8'hFE;
        re_go   = byte_done;
      end
      RD_DATA: if (cnt < 10'd512) begin
        tx_byte = pf_data;
        if (cnt < 10'd511) begin
          re_go  = byte_done;
          re_idx = cnt[8:0] + 9'd1;
        end
      end
      WR_DATA: begin
        if (cnt < 10'd512)  we_go   = byte_done;
        if (cnt == 10'd513) tx_byte = 8'h05;
      end
      WR_RESP: if (cnt < BUSY_CNT) tx_byte = 8'h00;
      default: tx_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge sys_clk_pad_i) begin
    if (rst) begin
      cnt        <= 10'd0;
      cmd_idx    <= 6'd0;
      arg        <= '0;
      illegal_q  <= 1'b0;
      app_cmd    <= 1'b0;
      idle_bit   <= 1'b1;
      card_ready <= 1'b0;
      pf_data    <= 8'hFF;
      rd_pend    <= 1'b0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= 8'h00;
    end else begin
      mem_re  <= re_go;
      mem_we  <= we_go;
      rd_pend <= mem_re;
      if (rd_pend) pf_data <= mem_rdata;
      if (re_go) mem_addr <= {arg[ADDR_W-10:0], re_idx};
      if (we_go) begin
        mem_addr  <= {arg[ADDR_W-10:0], cnt[8:0]};
        mem_wdata <= rx_byte;
      end
      if (cs_s || (state_nxt != state)) cnt <= 10'd0;
      else if (byte_done)               cnt <= cnt + 10'd1;
      if (byte_done) begin
        if ((state == WAIT_CMD) && (rx_byte[7:6] == 2'b01)) cmd_idx <= rx_byte[5:0];
        if ((state == CMD_RX) && (cnt < 10'd4)) arg <= ARG_W'({arg, rx_byte});
        if (state == NCR) begin
          illegal_q <= ~cmd_legal;
          app_cmd   <= (cmd_idx == 6'd55);
          if (cmd_idx == 6'd0) begin
            idle_bit   <= 1'b1;
            card_ready <= 1'b0;
          end
          if ((cmd_idx == 6'd41) && app_cmd) begin
            idle_bit   <= 1'b0;
            card_ready <= 1'b1;
          end
        end
      end
    end
  end
endmodule
